// File: rtl/pipe_stage_pkg.sv
// Shared types and arithmetic helpers for the stage sequencer and its vector lanes.
// Build option: define PIPE_STAGE_VPE_SAT_EN for saturating arithmetic; otherwise results wrap.
package pipe_stage_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_PAR   = 2;
  localparam int DEF_TILE  = 128;
  localparam int MAX_W     = 32;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

`ifdef PIPE_STAGE_VPE_SAT_EN
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int unsigned w);
    logic [2*MAX_W-1:0] s;
    logic [2*MAX_W-1:0] m;
    m = (64'd1 << w) - 64'd1;
    s = {{MAX_W{1'b0}}, a} + {{MAX_W{1'b0}}, b};
    if (s > m) s = m;
    return s[MAX_W-1:0];
  endfunction

  function automatic logic [MAX_W-1:0] sat_mul(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int unsigned w);
    logic [2*MAX_W-1:0] s;
    logic [2*MAX_W-1:0] m;
    m = (64'd1 << w) - 64'd1;
    s = {{MAX_W{1'b0}}, a} * {{MAX_W{1'b0}}, b};
    if (s > m) s = m;
    return s[MAX_W-1:0];
  endfunction
`else
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int unsigned w);
    logic [2*MAX_W-1:0] s;
    logic [2*MAX_W-1:0] m;
    m = (64'd1 << w) - 64'd1;
    s = ({{MAX_W{1'b0}}, a} + {{MAX_W{1'b0}}, b}) & m;
    return s[MAX_W-1:0];
  endfunction

  function automatic logic [MAX_W-1:0] sat_mul(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int unsigned w);
    logic [2*MAX_W-1:0] s;
    logic [2*MAX_W-1:0] m;
    m = (64'd1 << w) - 64'd1;
    s = ({{MAX_W{1'b0}}, a} * {{MAX_W{1'b0}}, b}) & m;
    return s[MAX_W-1:0];
  endfunction
`endif

endpackage

// File: rtl/pipe_stage_vpe_seq_if.sv
// Input and output beat streams of the vector-processing stage.
// master drives beats in and accepts results; slave is the stage itself.
interface pipe_stage_vpe_seq_if #(
  parameter int WIDTH = 16,
  parameter int PAR   = 2,
  parameter int TILE  = 128,
  parameter int ST_W  = 3
);
  logic                                   in_valid_i;
  logic                                   in_ready_o;
  logic [PAR-1:0][TILE-1:0][WIDTH-1:0]    vec_a_i;
  logic [PAR-1:0][TILE-1:0][WIDTH-1:0]    vec_b_i;
  logic [PAR-1:0][WIDTH-1:0]              bias_i;
  logic [PAR-1:0][WIDTH-1:0]              scale_i;
  logic                                   out_valid_o;
  logic                                   out_ready_i;
  logic [PAR-1:0][TILE-1:0][WIDTH-1:0]    vec_o;
  logic [PAR-1:0][WIDTH-1:0]              scal_o;
  logic [ST_W-1:0]                        out_stage_o;

  modport master (
    output in_valid_i, vec_a_i, vec_b_i, bias_i, scale_i, out_ready_i,
    input  in_ready_o, out_valid_o, vec_o, scal_o, out_stage_o
  );

  modport slave (
    input  in_valid_i, vec_a_i, vec_b_i, bias_i, scale_i, out_ready_i,
    output in_ready_o, out_valid_o, vec_o, scal_o, out_stage_o
  );
endinterface

// File: rtl/vpe_lane.sv
// One vector lane: registered products (P1), then elementwise copy or
// adder-tree reduce with bias and scale (P2). Reset is synchronous, active-low.
module vpe_lane
  import pipe_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TILE  = DEF_TILE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        adv,
  input  logic                        load,
  input  logic                        mode,
  input  logic [TILE-1:0][WIDTH-1:0]  a,
  input  logic [TILE-1:0][WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]            bias,
  input  logic [WIDTH-1:0]            scale,
  output logic [TILE-1:0][WIDTH-1:0]  vec,
  output logic [WIDTH-1:0]            scal
);

  logic [TILE-1:0][WIDTH-1:0] prod_d, prod_q;
  logic [WIDTH-1:0]           bias_q, scale_q;
  logic [MAX_W-1:0]           red;

  // Elementwise products of the incoming beat.
  always_comb begin
    prod_d = '0;
    for (int t = 0; t < TILE; t++)
      prod_d[t] = WIDTH'(sat_mul(MAX_W'(a[t]), MAX_W'(b[t]), WIDTH));
  end

  // P1 captures products and reduce operands only when a beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prod_q  <= '0;
      bias_q  <= '0;
      scale_q <= '0;
    end else if (adv && load) begin
      prod_q  <= prod_d;
      bias_q  <= bias;
      scale_q <= scale;
    end
  end

  // Reduce path: sum of products, plus bias, times scale.
  always_comb begin
    red = '0;
    for (int t = 0; t < TILE; t++)
      red = sat_add(red, MAX_W'(prod_q[t]), WIDTH);
    red = sat_add(red, MAX_W'(bias_q), WIDTH);
    red = sat_mul(red, MAX_W'(scale_q), WIDTH);
  end

  // P2 selects the vector or the scalar result; the other output reads zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vec  <= '0;
      scal <= '0;
    end else if (adv) begin
      vec  <= mode ? '0 : prod_q;
      scal <= mode ? WIDTH'(red) : '0;
    end
  end

endmodule

// File: rtl/pipe_stage_vpe_seq.sv
// Stage sequencer feeding a 2-deep vector-processing pipeline.
// Each stage spans a snapshotted number of beats and selects elementwise or reduce mode.
// Build option: PIPE_STAGE_VPE_SAT_EN selects saturating arithmetic in the lanes.
module pipe_stage_vpe_seq
  import pipe_stage_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PAR        = DEF_PAR,
  parameter int TILE       = DEF_TILE,
  parameter int NUM_STAGES = 7,
  parameter int CNT_W      = 8,
  parameter int ST_W       = $clog2(NUM_STAGES)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_STAGES-1:0][CNT_W-1:0] stage_boundary_i,
  input  logic [NUM_STAGES-1:0]            mode_mask_i,
  input  logic                             start_i,
  output logic [ST_W-1:0]                  stage_o,
  output logic                             busy_o,
  output logic                             finished_o,
  pipe_stage_vpe_seq_if.slave              bus
);

  state_t                          state_q, state_d;
  logic [NUM_STAGES-1:0][CNT_W-1:0] bnd_q;
  logic [NUM_STAGES-1:0]           mode_q;
  logic [ST_W-1:0]                 stage_q, stage_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            snap, next_stage;
  logic [CNT_W-1:0]                cur_bnd;
  logic                            adv, in_ready, fire;
  logic                            p1_valid, p1_mode, out_valid;
  logic [ST_W-1:0]                 p1_stage, out_stage;

  assign cur_bnd  = bnd_q[stage_q];
  assign adv      = !out_valid || bus.out_ready_i;
  assign in_ready = (state_q == RUN) && adv && (cur_bnd != '0);
  assign fire     = bus.in_valid_i && in_ready;

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_stage_o = out_stage;
  assign stage_o         = stage_q;
  assign busy_o          = (state_q != IDLE);
  assign finished_o      = (state_q == DONE);

  // Sequencer next state: beat counting, zero-length stages, drain and completion.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    cnt_d      = cnt_q;
    snap       = 1'b0;
    next_stage = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          stage_d = '0;
          cnt_d   = '0;
          snap    = 1'b1;
        end
      end
      RUN: begin
        if (cur_bnd == '0)
          next_stage = 1'b1;
        else if (fire) begin
          if (cnt_q == cur_bnd - CNT_W'(1))
            next_stage = 1'b1;
          else
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (next_stage) begin
          cnt_d = '0;
          if (stage_q == ST_W'(NUM_STAGES - 1))
            state_d = DRAIN;
          else
            stage_d = stage_q + ST_W'(1);
        end
      end
      DRAIN: begin
        if (!p1_valid && !out_valid)
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; the configuration is captured once at start.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      bnd_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      if (snap) begin
        bnd_q  <= stage_boundary_i;
        mode_q <= mode_mask_i;
      end
    end
  end

  // Pipeline valids and tags; a beat keeps the stage and mode it was accepted under.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      p1_valid  <= 1'b0;
      p1_mode   <= 1'b0;
      p1_stage  <= '0;
      out_valid <= 1'b0;
      out_stage <= '0;
    end else if (adv) begin
      p1_valid  <= fire;
      if (fire) begin
        p1_mode  <= mode_q[stage_q];
        p1_stage <= stage_q;
      end
      out_valid <= p1_valid;
      out_stage <= p1_stage;
    end
  end

  for (genvar p = 0; p < PAR; p++) begin : g_lane
    vpe_lane #(
      .WIDTH (WIDTH),
      .TILE  (TILE)
    ) u_lane (
      .clk   (clk_i),
      .rst   (rst_i),
      .adv   (adv),
      .load  (fire),
      .mode  (p1_mode),
      .a     (bus.vec_a_i[p]),
      .b     (bus.vec_b_i[p]),
      .bias  (bus.bias_i[p]),
      .scale (bus.scale_i[p]),
      .vec   (bus.vec_o[p]),
      .scal  (bus.scal_o[p])
    );
  end

endmodule

// File: doc/pipe_stage_vpe_seq.md
Name: pipe_stage_vpe_seq

Overview:
Parametrised successor of the stage-2 timing wrapper.
- Sequences a configurable number of stages, each spanning a programmable number of tile beats.
- Feeds beats through a 2-deep registered vector-processing pipeline with valid/ready handshakes on both sides.
- Per stage, the pipeline runs in elementwise mode (vector out) or reduce mode (scaled dot-product scalar out).
- Sits between the tile buffer and the downstream norm/softmax stage.

Parameters:
WIDTH, 16, element width (unsigned fixed-point)
PAR, 2, parallel lanes
TILE, 128, elements per lane per beat
NUM_STAGES, 7, number of sequenced stages
CNT_W, 8, width of per-stage beat count
ST_W, $clog2(NUM_STAGES), stage index width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-low
stage_boundary_i  in  NUM_STAGES x CNT_W  beats per stage; 0 = skip stage
mode_mask_i  in  NUM_STAGES  per-stage mode: 0 elementwise, 1 reduce
start_i  in  1  start a sequence (honoured only in IDLE)
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o
vec_a_i  in  PAR x TILE x WIDTH  operand A
vec_b_i  in  PAR x TILE x WIDTH  operand B
bias_i  in  PAR x WIDTH  reduce-mode bias
scale_i  in  PAR x WIDTH  reduce-mode scale
out_valid_o  out  1  output beat valid
out_ready_i  in  1  downstream ready
vec_o  out  PAR x TILE x WIDTH  elementwise result (0 in reduce mode)
scal_o  out  PAR x WIDTH  reduce result (0 in elementwise mode)
out_stage_o  out  ST_W  stage index tag of the output beat
stage_o  out  ST_W  current sequencer stage
busy_o  out  1  state != IDLE
finished_o  out  1  one-cycle pulse at sequence end

Behaviour:
Reset (rst_i=0 at posedge):
- All outputs and registers go to 0, state goes to IDLE.
- In-flight beats are discarded, including a reset mid-run.

FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start_i. Snapshot stage_boundary_i and mode_mask_i; clear stage and beat count.
- start_i outside IDLE is ignored. Config port changes after start have no effect.
- RUN, beat counting: each accepted beat increments the beat counter. The beat where count == boundary[stage]-1 sets count=0 and stage+1.
- RUN, zero-boundary stage: consumes exactly one cycle, accepts no beats (in_ready_o=0), then advances.
- RUN -> DRAIN: leaving stage NUM_STAGES-1 goes to DRAIN.
- DRAIN -> DONE when both pipeline valids are 0. DONE asserts finished_o for one cycle, then IDLE.
- stage_o: holds NUM_STAGES-1 in DRAIN/DONE; 0 in IDLE.

Pipeline and handshake:
- adv = !out_valid_o | out_ready_i. All pipeline registers load only on adv; otherwise everything holds.
- in_ready_o = (state==RUN) & adv & (boundary[stage]!=0).
- Latency: accepted beat appears on out_valid_o exactly 2 cycles later when unstalled.
- Output data and tag are stable while out_valid_o & !out_ready_i.
- P1: registers prod[p][t] = a*b mod 2^WIDTH, plus bias, scale, mode and stage tags.
- P2, mode 0: vec_o = prod, scal_o = 0.
- P2, mode 1: scal_o[p] = ((sum_t prod[p][t]) + bias[p]) * scale[p], each op mod 2^WIDTH. Adder tree is combinational within P2; vec_o = 0.

Simultaneous events and boundaries:
- Last beat of a stage is accepted while the stage advances: the beat carries the old stage tag and old mode.
- All boundaries 0: RUN lasts NUM_STAGES cycles. finished_o fires NUM_STAGES+2 cycles after start (DRAIN 1 cycle, DONE 1 cycle).
- Boundary 255 (CNT_W=8): exactly 255 beats, no counter wrap.

Optional Feature:
PIPE_STAGE_VPE_SAT_EN
- Defined: product, each adder-tree node, the bias add and the scale multiply saturate at 2^WIDTH-1.
- Undefined: plain wrap mod 2^WIDTH. Ports and timing are identical either way.

Decomposition:
- Package pipe_stage_pkg: state enum (IDLE/RUN/DRAIN/DONE), default WIDTH/TILE/PAR constants, and functions sat_add/sat_mul (wrap versions under `ifndef).
- Sub-module vpe_lane: one lane covering the P1 products, the P2 reduce and the bias/scale path. Instantiated PAR times via generate; the top holds the FSM, counters and handshake.

Test Plan:
- Boundaries {2,1,0,...,0}, mask {0,1,...}, a=3, b=5, bias=1, scale=2, out_ready held 1 -> 3 beats out at +2 cycles each. Beats 0-1: vec_o all 15, tag 0. Beat 2: scal_o=(128*15+1)*2 mod 65536=3842, tag 1. finished_o pulse after drain.
- Same config, out_ready_i low for 5 cycles mid-run -> in_ready_o low, outputs stable, no beat lost or duplicated, order preserved.
- All boundaries 0 -> no in_ready_o, finished_o exactly NUM_STAGES+2 cycles after start.
- rst_i low for one cycle during stage 1 with 2 beats in flight -> next cycle all outputs 0, IDLE, the in-flight beats never emerge.
- start_i pulsed in RUN and boundaries changed mid-run -> ignored; beat counts follow the snapshot.
- SAT_EN build: a=b=0xFFFF, mode 1 -> scal_o=0xFFFF. Without SAT_EN: prod=1, sum=128, scal_o=(128+bias)*scale mod 2^16.
